// File: rtl/rx_frame_pkg.sv
// rx_frame_pkg: parity modes, queued entry layout and frame-width helper for the Rx frame extractor
package rx_frame_pkg;
    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;
    localparam int MAX_DATA_W  = 9;
    typedef struct packed {
        logic                  framing_err;
        logic                  parity_err;
        logic                  parity_bit;
        logic [MAX_DATA_W-1:0] data;
    } entry_t;
    function automatic int pkt_w(input int data_w, input int parity_mode, input int stop_bits);
        return 1 + data_w + ((parity_mode != PARITY_NONE) ? 1 : 0) + stop_bits;
    endfunction
endpackage

// File: rtl/rx_frame_fifo.sv
// rx_frame_fifo: synchronous FIFO; a push into a full queue is accepted only alongside a pop
module rx_frame_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wr_data,
    output logic [W-1:0] rd_data,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic          do_push, do_pop;
    assign empty   = count_q == '0;
    assign full    = count_q == (AW+1)'(DEPTH);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rd_data = mem_q[rd_ptr_q];
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) mem_q[wr_ptr_q] <= wr_data;
            wr_ptr_q <= wr_ptr_q + AW'(do_push);
            rd_ptr_q <= rd_ptr_q + AW'(do_pop);
            count_q  <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/rx_frame_extractor.sv
// rx_frame_extractor: captures Rx frames on the completion strobe's rising edge, checks them and queues the results
module rx_frame_extractor import rx_frame_pkg::*; #(
    parameter int DATA_W      = 8,
    parameter int PARITY_MODE = 1,
    parameter int STOP_BITS   = 1,
    parameter int FIFO_DEPTH  = 4,
    parameter int CNT_W       = 8,
    localparam int PKT_W      = pkt_w(DATA_W, PARITY_MODE, STOP_BITS)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [PKT_W-1:0]  packet,
    input  logic              packet_completion,
    input  logic              out_ready,
    input  logic              clear_overrun,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_parity_bit,
    output logic              out_parity_err,
    output logic              out_framing_err,
    output logic              overrun,
    output logic [CNT_W-1:0]  frame_count,
    output logic [CNT_W-1:0]  error_count
);
    logic              prev_q, overrun_q;
    logic [CNT_W-1:0]  frame_q, error_q;
    logic              capture, pop, full, empty, drop, par, par_exp;
    logic [DATA_W-1:0] data;
    entry_t            entry_d, head;
    assign capture = packet_completion & ~prev_q;
    assign data    = packet[DATA_W:1];
    assign par     = (PARITY_MODE != PARITY_NONE) ? packet[DATA_W+1] : 1'b0;
    assign par_exp = (PARITY_MODE == PARITY_ODD) ? ~^data : ^data;
    always_comb begin
        entry_d             = '0;
        entry_d.data        = MAX_DATA_W'(data);
        entry_d.parity_bit  = par;
        entry_d.parity_err  = (PARITY_MODE != PARITY_NONE) && (par != par_exp);
        entry_d.framing_err = packet[0] | ~&packet[PKT_W-1 -: STOP_BITS];
    end
    assign pop  = ~empty & out_ready;
    assign drop = capture & full & ~pop;
    rx_frame_fifo #(.W($bits(entry_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (capture),
        .pop     (pop),
        .wr_data (entry_d),
        .rd_data (head),
        .full    (full),
        .empty   (empty)
    );
    // prev_q resets high so a strobe already asserted at reset release is not treated as a new frame
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            prev_q    <= 1'b1;
            overrun_q <= 1'b0;
            frame_q   <= '0;
            error_q   <= '0;
        end else begin
            prev_q    <= packet_completion;
            overrun_q <= drop | (overrun_q & ~clear_overrun);
            frame_q   <= frame_q + CNT_W'(capture & ~&frame_q);
            error_q   <= error_q + CNT_W'(capture & (entry_d.parity_err | entry_d.framing_err) & ~&error_q);
        end
    end
    assign out_valid       = ~empty;
    assign out_data        = DATA_W'(head.data);
    assign out_parity_bit  = head.parity_bit;
    assign out_parity_err  = head.parity_err;
    assign out_framing_err = head.framing_err;
    assign overrun         = overrun_q;
    assign frame_count     = frame_q;
    assign error_count     = error_q;
endmodule

// File: tb/tb_rx_frame_extractor.sv
// tb_rx_frame_extractor: directed checks of capture, error flags, FIFO full/overrun, reset and the odd-parity/2-stop variant
module tb_rx_frame_extractor;
    logic        clk = 1'b0;
    logic        reset_n;
    logic [10:0] packet;
    logic        stb_a, rdy_a, clr_a, stb_b, rdy_b, clr_b;
    logic        va, pba, pea, fea, ova;
    logic [7:0]  da, fca, eca;
    logic        vb, pbb, peb, feb, ovb;
    logic [6:0]  db;
    logic [7:0]  fcb, ecb;
    int          n_chk = 0;
    int          n_fail = 0;
    logic [7:0]  exp_q [4] = '{8'h11, 8'h12, 8'h13, 8'h3C};

    always #5 clk = ~clk;

    rx_frame_extractor dut_a (
        .clk(clk), .reset_n(reset_n), .packet(packet), .packet_completion(stb_a),
        .out_ready(rdy_a), .clear_overrun(clr_a), .out_valid(va), .out_data(da),
        .out_parity_bit(pba), .out_parity_err(pea), .out_framing_err(fea),
        .overrun(ova), .frame_count(fca), .error_count(eca)
    );

    rx_frame_extractor #(.DATA_W(7), .PARITY_MODE(2), .STOP_BITS(2)) dut_b (
        .clk(clk), .reset_n(reset_n), .packet(packet), .packet_completion(stb_b),
        .out_ready(rdy_b), .clear_overrun(clr_b), .out_valid(vb), .out_data(db),
        .out_parity_bit(pbb), .out_parity_err(peb), .out_framing_err(feb),
        .overrun(ovb), .frame_count(fcb), .error_count(ecb)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset_n = 1'b0;
        tick;
        reset_n = 1'b1;
        tick;
    endtask

    task automatic frame_a(input logic [10:0] p);
        packet = p;
        stb_a = 1'b1;
        tick;
        stb_a = 1'b0;
        tick;
    endtask

    task automatic frame_b(input logic [10:0] p);
        packet = p;
        stb_b = 1'b1;
        tick;
        stb_b = 1'b0;
        tick;
    endtask

    task automatic pop_a;
        rdy_a = 1'b1;
        tick;
        rdy_a = 1'b0;
    endtask

    task automatic pop_b;
        rdy_b = 1'b1;
        tick;
        rdy_b = 1'b0;
    endtask

    // 8-bit even-parity, 1-stop frame: {stop, parity, data, start}
    function automatic logic [10:0] mk(input logic [7:0] d);
        return {1'b1, ^d, d, 1'b0};
    endfunction

    initial begin
        reset_n = 1'b0;
        packet = '0;
        {stb_a, rdy_a, clr_a, stb_b, rdy_b, clr_b} = '0;
        tick;
        tick;
        check("rst_valid", 32'(va), 0);
        check("rst_data", 32'(da), 0);
        check("rst_overrun", 32'(ova), 0);
        check("rst_frames", 32'(fca), 0);
        reset_n = 1'b1;
        tick;

        packet = 11'h54A;
        stb_a = 1'b1;
        tick;
        check("cap_valid", 32'(va), 1);
        check("cap_data", 32'(da), 32'hA5);
        check("cap_perr", 32'(pea), 0);
        check("cap_ferr", 32'(fea), 0);
        check("cap_frames", 32'(fca), 1);
        stb_a = 1'b0;
        pop_a;
        check("pop_empty", 32'(va), 0);

        frame_a(11'h74A);
        check("par_perr", 32'(pea), 1);
        check("par_pbit", 32'(pba), 1);
        check("par_errcnt", 32'(eca), 1);
        pop_a;
        frame_a(11'h14A);
        check("stop_ferr", 32'(fea), 1);
        check("stop_perr", 32'(pea), 0);
        check("stop_errcnt", 32'(eca), 2);
        check("stop_frames", 32'(fca), 3);
        pop_a;

        do_reset;
        for (int i = 1; i <= 5; i++) frame_a(mk(8'(i)));
        check("ovf_overrun", 32'(ova), 1);
        check("ovf_frames", 32'(fca), 5);
        check("ovf_errcnt", 32'(eca), 0);
        for (int i = 1; i <= 4; i++) begin
            check("drain_valid", 32'(va), 1);
            check("drain_data", 32'(da), 32'(i));
            pop_a;
        end
        check("drain_empty", 32'(va), 0);
        check("ovr_sticky", 32'(ova), 1);
        clr_a = 1'b1;
        tick;
        clr_a = 1'b0;
        check("ovr_clear", 32'(ova), 0);

        for (int i = 8'h10; i <= 8'h13; i++) frame_a(mk(8'(i)));
        packet = mk(8'h3C);
        check("full_pkt", 32'(packet), 32'h478);
        stb_a = 1'b1;
        rdy_a = 1'b1;
        tick;
        stb_a = 1'b0;
        rdy_a = 1'b0;
        check("fullpop_overrun", 32'(ova), 0);
        check("fullpop_frames", 32'(fca), 10);
        for (int i = 0; i < 4; i++) begin
            check("fullpop_data", 32'(da), 32'(exp_q[i]));
            pop_a;
        end
        check("fullpop_empty", 32'(va), 0);

        packet = mk(8'h55);
        stb_a = 1'b1;
        repeat (10) tick;
        stb_a = 1'b0;
        tick;
        check("hold_frames", 32'(fca), 11);
        check("hold_data", 32'(da), 32'h55);
        pop_a;
        check("hold_single", 32'(va), 0);

        frame_a(mk(8'h66));
        frame_a(mk(8'h77));
        packet = mk(8'h88);
        stb_a = 1'b1;
        tick;
        reset_n = 1'b0;
        tick;
        reset_n = 1'b1;
        check("midrst_valid", 32'(va), 0);
        check("midrst_frames", 32'(fca), 0);
        check("midrst_errcnt", 32'(eca), 0);
        repeat (3) tick;
        check("stuck_valid", 32'(va), 0);
        check("stuck_frames", 32'(fca), 0);
        stb_a = 1'b0;
        tick;
        stb_a = 1'b1;
        tick;
        stb_a = 1'b0;
        check("rearm_valid", 32'(va), 1);
        check("rearm_data", 32'(da), 32'h88);
        check("rearm_frames", 32'(fca), 1);
        tick;

        frame_b(11'h782);
        check("odd_valid", 32'(vb), 1);
        check("odd_data", 32'(db), 32'h41);
        check("odd_pbit", 32'(pbb), 1);
        check("odd_perr", 32'(peb), 0);
        check("odd_ferr", 32'(feb), 0);
        pop_b;
        frame_b(11'h682);
        check("odd_bad_perr", 32'(peb), 1);
        check("odd_bad_pbit", 32'(pbb), 0);
        pop_b;
        frame_b(11'h382);
        check("stop2_ferr", 32'(feb), 1);
        check("stop2_perr", 32'(peb), 0);
        check("b_errcnt", 32'(ecb), 2);
        check("b_frames", 32'(fcb), 3);
        check("b_overrun", 32'(ovb), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
